// File: rtl/fifo_ms_pkg.sv
// Shared types and helpers for the multi-stream tagged FIFO and its readers.
// Holds the output-buffer state encoding and the round-robin scan function.
package fifo_ms_pkg;

  localparam int MAX_FLUX = 32;
  localparam int IDX_W    = $clog2(MAX_FLUX);

  typedef logic [IDX_W-1:0] rr_idx_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  typedef struct packed {
    logic    found;
    rr_idx_t idx;
  } rr_result_t;

  // First non-empty stream scanning start+1, start+2, ... mod flux, ending at start.
  function automatic rr_result_t rr_next(input logic [MAX_FLUX-1:0] empty,
                                         input rr_idx_t             start,
                                         input int                  flux);
    rr_result_t res;
    int         pos;
    res = '0;
    for (int i = 1; i <= MAX_FLUX; i++) begin
      pos = int'(start) + i;
      if (pos >= flux) pos -= flux;
      if ((i <= flux) && !res.found && !empty[rr_idx_t'(pos)]) begin
        res.found = 1'b1;
        res.idx   = rr_idx_t'(pos);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_ms_rr_reader_rr_arbiter.sv
// Round-robin arbiter with per-grant burst allowance for the tagged-FIFO reader.
// Stays on the current stream while it has data and burst credit, otherwise rotates.
module rr_arbiter
  import fifo_ms_pkg::*;
#(
  parameter int FLUX  = 2,
  parameter int BURST = 1
) (
  input  logic [FLUX-1:0]              req,
  input  logic [$clog2(FLUX)-1:0]      g,
  input  logic [$clog2(BURST+1)-1:0]   burst_cnt,
  output logic [FLUX-1:0]              grant_oh,
  output logic [$clog2(FLUX)-1:0]      grant_idx,
  output logic                         found
);

  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int CNT_W     = $clog2(BURST+1);

  logic [MAX_FLUX-1:0] empty_pad;
  rr_result_t          scan;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    empty_pad             = '1;
    empty_pad[FLUX-1:0]   = ~req;
    scan                  = rr_next(empty_pad, rr_idx_t'(g), FLUX);
    grant_idx             = scan.idx[TAG_WIDTH-1:0];
    found                 = scan.found && (int'(scan.idx) < FLUX);
    if (req[g] && (burst_cnt < CNT_W'(BURST))) begin
      grant_idx = g;
      found     = 1'b1;
    end
    grant_oh = found ? (FLUX'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/fifo_ms_rr_reader.sv
// Drain stage for the multi-stream tagged FIFO: round-robin pops into a
// 2-entry valid/ready output buffer, with a sticky tag-consistency flag.
module fifo_ms_rr_reader
  import fifo_ms_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int BURST      = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FLUX-1:0]                      fifo_empty,
  input  logic [DATA_WIDTH+$clog2(FLUX)-1:0]   fifo_dout,
  output logic [FLUX-1:0]                      fifo_read,
  output logic [DATA_WIDTH+$clog2(FLUX)-1:0]   out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 tag_err
);

  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WORD_W    = DATA_WIDTH + TAG_WIDTH;
  localparam int CNT_W     = $clog2(BURST+1);

  buf_state_t             state, next_state;
  logic [WORD_W-1:0]      buf_mem [2];
  logic                   wr_ptr, rd_ptr;
  logic [TAG_WIDTH-1:0]   g;
  logic [CNT_W-1:0]       burst_cnt;

  logic [FLUX-1:0]        grant_oh;
  logic [TAG_WIDTH-1:0]   grant_idx;
  logic                   found;
  logic                   space, push, pop;

  rr_arbiter #(
    .FLUX  (FLUX),
    .BURST (BURST)
  ) u_arb (
    .req       (~fifo_empty),
    .g         (g),
    .burst_cnt (burst_cnt),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .found     (found)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) state <= BUF_EMPTY;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BUF_EMPTY: if (push) next_state = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      next_state = BUF_TWO;
        else if (!push && pop) next_state = BUF_EMPTY;
      end
      BUF_TWO:   if (pop) next_state = BUF_ONE;
      default:   next_state = BUF_EMPTY;
    endcase
  end

  // Pop decision depends only on registered state and the FIFO flags, never on out_ready.
  always_comb begin
    out_valid = (state != BUF_EMPTY);
    space     = (state != BUF_TWO);
    push      = rst && space && found;
    pop       = out_valid && out_ready;
    fifo_read = push ? grant_oh : '0;
    out_data  = out_valid ? buf_mem[rd_ptr] : '0;
  end

  // NOTE: the buffer storage has no reset; out_data is gated by out_valid so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      g         <= '0;
      burst_cnt <= '0;
      tag_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push) begin
        if (grant_idx == g) begin
          // Saturate so a long solo run cannot wrap back into fresh burst credit.
          if (burst_cnt != CNT_W'(BURST)) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          g         <= grant_idx;
          burst_cnt <= CNT_W'(1);
        end
        if (fifo_dout[WORD_W-1 -: TAG_WIDTH] != grant_idx) tag_err <= 1'b1;
      end
    end
  end

  a_read_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(fifo_read));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    (fifo_read & fifo_empty) == '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !((state == BUF_TWO) && (fifo_read != '0)));

endmodule

// File: tb/tb_fifo_ms_rr_reader.sv
// Bench for fifo_ms_rr_reader: two instances (BURST=2 and BURST=1) fed by a
// behavioural multi-stream FIFO, with a scoreboard on the output handshake.
module tb_fifo_ms_rr_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] fifo_empty_a, fifo_read_a, fifo_empty_b, fifo_read_b;
  logic [9:0] fifo_dout_a, out_data_a, fifo_dout_b, out_data_b;
  logic       out_valid_a, out_ready_a, tag_err_a;
  logic       out_valid_b, out_ready_b, tag_err_b;

  logic [9:0] mem  [0:1][0:3][0:15];
  int         wptr [0:1][0:3];
  int         rptr [0:1][0:3];
  logic [9:0] sb_a [$];
  logic [9:0] sb_b [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  fifo_ms_rr_reader #(.DATA_WIDTH(8), .FLUX(4), .BURST(2)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_a), .fifo_dout(fifo_dout_a),
    .fifo_read(fifo_read_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .tag_err(tag_err_a));

  fifo_ms_rr_reader #(.DATA_WIDTH(8), .FLUX(4), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_b), .fifo_dout(fifo_dout_b),
    .fifo_read(fifo_read_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .tag_err(tag_err_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk_word(input int tag, input logic [7:0] d);
    return {2'(tag), d};
  endfunction

  task automatic load(input int inst, input int f, input logic [9:0] word);
    mem[inst][f][4'(wptr[inst][f])] = word;
    wptr[inst][f]++;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Behavioural FIFO: flags and combinational head word per stream.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fifo_empty_a[k] = (rptr[0][k] == wptr[0][k]);
      fifo_empty_b[k] = (rptr[1][k] == wptr[1][k]);
    end
  end

  always_comb begin
    fifo_dout_a = '0;
    fifo_dout_b = '0;
    for (int k = 0; k < 4; k++) begin
      if (fifo_read_a[k]) fifo_dout_a = mem[0][k][4'(rptr[0][k])];
      if (fifo_read_b[k]) fifo_dout_b = mem[1][k][4'(rptr[1][k])];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fifo_read_a[k]) begin
        check("no_underflow_a", fifo_empty_a[k], 1'b0);
        rptr[0][k] <= rptr[0][k] + 1;
      end
      if (fifo_read_b[k]) begin
        check("no_underflow_b", fifo_empty_b[k], 1'b0);
        rptr[1][k] <= rptr[1][k] + 1;
      end
    end
  end

  // Scoreboard monitor: every accepted head word must match the next expected word.
  always @(negedge clk) begin
    if (rst && out_valid_a && out_ready_a) begin
      check("sb_a_pending", sb_a.size() != 0, 1'b1);
      if (sb_a.size() != 0) check("out_data_a", out_data_a, sb_a.pop_front());
    end
    if (rst && out_valid_b && out_ready_b) begin
      check("sb_b_pending", sb_b.size() != 0, 1'b1);
      if (sb_b.size() != 0) check("out_data_b", out_data_b, sb_b.pop_front());
    end
  end

  logic [3:0] b_seq [8];

  initial begin
    rst         = 1'b0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 4; i++) load(0, f, mk_word(f, 8'(f * 16 + i)));
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 4; f++)
        for (int j = 0; j < 2; j++) sb_a.push_back(mk_word(f, 8'(f * 16 + r * 2 + j)));

    // Reset held with every stream non-empty.
    repeat (3) begin
      @(negedge clk);
      check("rst_read_a", fifo_read_a, 4'b0000);
      check("rst_valid_a", out_valid_a, 1'b0);
      check("rst_tag_err_a", tag_err_a, 1'b0);
      check("rst_data_a", out_data_a, 10'h000);
    end

    // Sustained drain, BURST=2: two pops per stream in rotation.
    drive_edge();
    rst = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("rr_burst_read", fifo_read_a, 4'b0001 << ((c / 2) % 4));
      check("stream_valid", out_valid_a, c >= 1);
    end
    @(negedge clk);
    check("drained_read", fifo_read_a, 4'b0000);
    check("last_valid", out_valid_a, 1'b1);
    @(negedge clk);
    check("empty_valid", out_valid_a, 1'b0);

    // Backpressure: buffer fills to two, then reads stop until the consumer drains.
    drive_edge();
    out_ready_a = 1'b0;
    load(0, 0, mk_word(0, 8'hA1));
    load(0, 0, mk_word(0, 8'hA2));
    load(0, 0, mk_word(0, 8'hA3));
    sb_a.push_back(mk_word(0, 8'hA1));
    sb_a.push_back(mk_word(0, 8'hA2));
    sb_a.push_back(mk_word(0, 8'hA3));
    @(negedge clk);
    check("bp_pop1", fifo_read_a, 4'b0001);
    check("bp_valid0", out_valid_a, 1'b0);
    @(negedge clk);
    check("bp_pop2", fifo_read_a, 4'b0001);
    check("bp_head", out_data_a, mk_word(0, 8'hA1));
    repeat (2) begin
      @(negedge clk);
      check("bp_full_stall", fifo_read_a, 4'b0000);
      check("bp_head_hold", out_data_a, mk_word(0, 8'hA1));
    end
    drive_edge();
    out_ready_a = 1'b1;
    @(negedge clk);
    check("bp_no_ready_path", fifo_read_a, 4'b0000);
    @(negedge clk);
    check("bp_resume", fifo_read_a, 4'b0001);
    check("bp_second", out_data_a, mk_word(0, 8'hA2));
    @(negedge clk);
    check("bp_third", out_data_a, mk_word(0, 8'hA3));
    check("bp_done_read", fifo_read_a, 4'b0000);

    // Tag mismatch: stream 1 delivers a word tagged 3.
    drive_edge();
    load(0, 1, mk_word(3, 8'h5C));
    sb_a.push_back(mk_word(3, 8'h5C));
    @(negedge clk);
    check("tag_pop", fifo_read_a, 4'b0010);
    check("tag_err_before", tag_err_a, 1'b0);
    @(negedge clk);
    check("tag_err_set", tag_err_a, 1'b1);
    check("tag_word_fwd", out_data_a, mk_word(3, 8'h5C));
    repeat (3) begin
      @(negedge clk);
      check("tag_err_sticky", tag_err_a, 1'b1);
    end

    // BURST=1: streams 2 and 3 alternate; stream 1 joins mid-run.
    b_seq = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    drive_edge();
    for (int i = 0; i < 3; i++) begin
      load(1, 2, mk_word(2, 8'(8'h20 + i)));
      load(1, 3, mk_word(3, 8'(8'h30 + i)));
    end
    sb_b.push_back(mk_word(2, 8'h20));
    sb_b.push_back(mk_word(3, 8'h30));
    sb_b.push_back(mk_word(2, 8'h21));
    sb_b.push_back(mk_word(3, 8'h31));
    sb_b.push_back(mk_word(1, 8'h10));
    sb_b.push_back(mk_word(2, 8'h22));
    sb_b.push_back(mk_word(3, 8'h32));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_strict_read", fifo_read_b, b_seq[c]);
      if (c == 2) begin
        drive_edge();
        load(1, 1, mk_word(1, 8'h10));
      end
    end

    // Reset with the buffer full: contents discarded, pointer back to stream 0.
    drive_edge();
    out_ready_a = 1'b0;
    load(0, 2, mk_word(2, 8'hB1));
    load(0, 2, mk_word(2, 8'hB2));
    load(0, 3, mk_word(3, 8'hC1));
    @(negedge clk);
    check("pre_rst_pop1", fifo_read_a, 4'b0100);
    @(negedge clk);
    check("pre_rst_pop2", fifo_read_a, 4'b0100);
    @(negedge clk);
    check("pre_rst_full", out_valid_a, 1'b1);
    drive_edge();
    rst = 1'b0;
    load(0, 1, mk_word(1, 8'hD1));
    @(negedge clk);
    check("rst_blocks_read", fifo_read_a, 4'b0000);
    @(negedge clk);
    check("rst_clears_valid", out_valid_a, 1'b0);
    check("rst_clears_data", out_data_a, 10'h000);
    check("rst_clears_tag_err", tag_err_a, 1'b0);
    drive_edge();
    rst         = 1'b1;
    out_ready_a = 1'b1;
    sb_a.push_back(mk_word(1, 8'hD1));
    sb_a.push_back(mk_word(3, 8'hC1));
    @(negedge clk);
    check("g_restart", fifo_read_a, 4'b0010);
    @(negedge clk);
    check("post_rst_next", fifo_read_a, 4'b1000);
    check("post_rst_head", out_data_a, mk_word(1, 8'hD1));

    for (int i = 0; i < 50 && (sb_a.size() != 0 || sb_b.size() != 0); i++) @(negedge clk);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    check("final_tag_err_a", tag_err_a, 1'b0);
    check("final_tag_err_b", tag_err_b, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ms_rr_reader.md
Name: fifo_ms_rr_reader

Overview:
- Drain stage directly downstream of the multi-stream tagged FIFO.
- Watches the FIFO's per-flux empty flags and issues one-hot read pops.
- Captures the FIFO's combinational {tag,data} output into a 2-entry output buffer with valid/ready handshake.
- Round-robin arbitration across fluxes, with a configurable burst length per grant.

Parameters:
- DATA_WIDTH, 8, payload width per word.
- FLUX, 2, number of tagged streams; must be ≥2.
- BURST, 1, max consecutive pops from one flux while others wait; ≥1.
- TAG_WIDTH, $clog2(FLUX), derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset. rst==0 at a clk edge resets all state.
- fifo_empty  in  FLUX  per-flux empty flags from the FIFO.
- fifo_dout  in  DATA_WIDTH+TAG_WIDTH  FIFO output {tag,data}; valid combinationally for the flux selected by fifo_read.
- fifo_read  out  FLUX  one-hot pop request, combinational; all-zero when idle.
- out_data  out  DATA_WIDTH+TAG_WIDTH  head word {tag,data}.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts head when out_valid&&out_ready at clk edge.
- tag_err  out  1  sticky; set when a captured tag differs from the granted flux index.

Behaviour:
- Reset (rst==0), all outputs/state forced:
  - grant pointer g=0, burst_cnt=0, buffer count cnt=0.
  - out_valid=0, out_data=0, tag_err=0.
  - fifo_read=0 combinationally while rst==0.
- Buffer: 2-entry FIFO, states EMPTY/ONE/TWO.
  - out_valid = (cnt!=0); out_data = oldest entry.
- Pop enable: space = (cnt<2). No combinational path from out_ready to fifo_read.
- Candidate selection (combinational):
  - If !fifo_empty[g] and burst_cnt<BURST, candidate = g.
  - Otherwise, candidate = first non-empty flux scanning g+1, g+2, … mod FLUX, ending with g itself.
  - If all fluxes are empty, there is no candidate.
- Pop: when space and a candidate exists:
  - fifo_read = onehot(candidate).
  - fifo_dout is written into the buffer at the same edge.
- Pointer update on pop:
  - candidate==g: burst_cnt<=burst_cnt+1.
  - Otherwise: g<=candidate, burst_cnt<=1.
  - With BURST=1 this gives strict round-robin.
- No pop: g and burst_cnt hold.
- Simultaneous push and pop in the same cycle (pop from FIFO, out_valid&&out_ready): cnt unchanged, order preserved.
- Throughput: 1 word/cycle sustained when out_ready is held high (cnt oscillates at ONE). With out_ready low, the buffer fills to TWO, then fifo_read=0.
- Latency: FIFO word to out_valid is 1 cycle.
- tag_err: at a pop, if fifo_dout[top TAG_WIDTH bits] != candidate, tag_err<=1. The word is still forwarded unchanged. tag_err clears only on reset.
- Wrap-around: scan index mod FLUX; g wraps FLUX-1 → 0.
- Reset mid-operation: buffered words are discarded and no pop is issued that cycle. The FIFO's own pointers are unaffected by this block.
- Pops are never issued to an empty flux (reader-side underflow protection).

Decomposition:
- Shared package fifo_ms_pkg:
  - enum buf_state_t {BUF_EMPTY, BUF_ONE, BUF_TWO}.
  - Function rr_next(empty vector, start index) returning index+found flag.
- Natural sub-module: rr_arbiter.
  - Inputs: request vector, pointer g, burst_cnt.
  - Outputs: one-hot grant, grant index, found.
  - Instantiated once.

Test Plan (DATA_WIDTH=8, FLUX=4, BURST=2 unless stated):
- Hold rst=0 for 3 cycles with fifo_empty=4'b0000 → fifo_read=0, out_valid=0, tag_err=0 throughout. Release → first pop fifo_read=4'b0001 next cycle.
- All fluxes non-empty, out_ready=1 → fifo_read sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001… and out_valid continuous from cycle 2.
- BURST=1, only flux 2 and 3 non-empty → alternating 0100,1000. Flux 1 turns non-empty mid-run → inserted after the current pop in rotation order (3→0 skip→1).
- out_ready=0 with flux 0 holding words 0xA1,0xA2,0xA3 → exactly two pops, then fifo_read=0. Raise out_ready → out_data {2'd0,0xA1} then {2'd0,0xA2}, then the third pop resumes.
- fifo_dout tag=2'd3 while grant is flux 1 → tag_err=1 next cycle and stays 1 until rst=0. The word is still delivered.
- Reset asserted with cnt=TWO → out_valid=0 next cycle, buffer contents are never seen, and g restarts at flux 0.
